// File: rtl/pedo_issue_ctrl_pkg.sv
// Shared constants and types for the pedometer issue controller.
// Holds execution-unit function codes, command opcodes, weight indices and FSM states.
package pedo_issue_ctrl_pkg;

    localparam logic [2:0] FUNCT_COUNT = 3'd1;
    localparam logic [2:0] FUNCT_NOP   = 3'd7;

    localparam logic [2:0] OP_CLEAR_COUNT = 3'd0;
    localparam logic [2:0] OP_LOAD_WEIGHT = 3'd2;

    localparam int NUM_WEIGHTS = 6;

    localparam logic [2:0] W_THETA1_1 = 3'd0;
    localparam logic [2:0] W_THETA1_2 = 3'd1;
    localparam logic [2:0] W_THETA2_1 = 3'd2;
    localparam logic [2:0] W_THETA2_2 = 3'd3;
    localparam logic [2:0] W_ALPHA1   = 3'd4;
    localparam logic [2:0] W_ALPHA2   = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_COMMIT
    } issue_state_e;

    function automatic logic is_weight_sel(input logic [2:0] sel);
        return sel <= W_ALPHA2;
    endfunction

endpackage

// File: rtl/pedo_sample_fifo.sv
// Sample FIFO holding packed {x, y} accelerometer pairs.
// ready comes from the registered occupancy only, so a full FIFO never accepts even when popping.
module pedo_sample_fifo
    import pedo_issue_ctrl_pkg::*;
#(
    parameter int DATA_W     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                push,
    input  logic [2*DATA_W-1:0] push_data,
    input  logic                pop,
    output logic [2*DATA_W-1:0] head_data,
    output logic                empty,
    output logic                ready
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    logic [2*DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W:0]      count;
    logic                full;
    logic                do_push;
    logic                do_pop;

    assign full      = (count == CNT_FULL);
    assign empty     = (count == '0);
    assign ready     = enable && !full;
    assign do_push   = push && ready;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pedo_issue_ctrl.sv
// Pedometer issue controller: queues samples, issues them to the execution unit,
// commits the returned step count and services weight/clear commands between samples.
module pedo_issue_ctrl
    import pedo_issue_ctrl_pkg::*;
#(
    parameter int DATA_W     = 10,
    parameter int EX_LATENCY = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    input  logic [DATA_W-1:0]             sample_x,
    input  logic [DATA_W-1:0]             sample_y,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [2:0]                    cmd_op,
    input  logic [2:0]                    cmd_sel,
    input  logic [DATA_W-1:0]             cmd_data,
    output logic [DATA_W-1:0]             ex_A,
    output logic [DATA_W-1:0]             ex_B,
    output logic [2:0]                    ex_funct,
    output logic [NUM_WEIGHTS*DATA_W-1:0] ex_weights,
    output logic [DATA_W-1:0]             ex_totalSteps,
    input  logic                          ex_step,
    input  logic [DATA_W-1:0]             ex_updatedSteps,
    output logic [DATA_W-1:0]             step_count,
    output logic                          step_pulse,
    output logic                          busy,
    output logic                          overflow
);

    // WAIT covers EX_LATENCY-1 cycles; the counter is loaded while in ISSUE.
    localparam logic [1:0] WAIT_INIT = 2'((EX_LATENCY > 1) ? EX_LATENCY - 2 : 0);

    issue_state_e        state;
    issue_state_e        state_next;
    logic [1:0]          wait_cnt;
    logic                run_en;
    logic                fifo_pop;
    logic                fifo_empty;
    logic [2*DATA_W-1:0] fifo_head;
    logic [DATA_W-1:0]   weights [NUM_WEIGHTS];

    pedo_sample_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (run_en),
        .push      (sample_valid),
        .push_data ({sample_x, sample_y}),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .ready     (sample_ready)
    );

    assign busy = (state != ST_IDLE) || !fifo_empty;

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        fifo_pop   = 1'b0;
        ex_funct   = FUNCT_NOP;
        step_pulse = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run_en && cmd_valid) begin
                    cmd_ready = 1'b1;
                end else if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                ex_funct   = FUNCT_COUNT;
                state_next = (EX_LATENCY > 1) ? ST_WAIT : ST_COMMIT;
            end
            ST_WAIT: begin
                ex_funct = FUNCT_COUNT;
                if (wait_cnt == 2'd0) begin
                    state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                step_pulse = ex_step;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            run_en <= 1'b0;
        end else begin
            state  <= state_next;
            run_en <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt      <= 2'd0;
            ex_A          <= '0;
            ex_B          <= '0;
            ex_totalSteps <= '0;
            step_count    <= '0;
            overflow      <= 1'b0;
        end else begin
            if (fifo_pop) begin
                ex_A          <= fifo_head[2*DATA_W-1:DATA_W];
                ex_B          <= fifo_head[DATA_W-1:0];
                ex_totalSteps <= step_count;
            end
            if (state == ST_ISSUE) begin
                wait_cnt <= WAIT_INIT;
            end else if (state == ST_WAIT && wait_cnt != 2'd0) begin
                wait_cnt <= wait_cnt - 2'd1;
            end
            // Count wraps modulo 2^DATA_W; a step taken from all-ones marks overflow.
            if (state == ST_COMMIT) begin
                step_count <= ex_updatedSteps;
                if (ex_step && step_count == '1) begin
                    overflow <= 1'b1;
                end
            end
            if (cmd_ready && cmd_op == OP_CLEAR_COUNT) begin
                step_count <= '0;
                overflow   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WEIGHTS; i++) begin
                weights[i] <= '0;
            end
        end else if (cmd_ready && cmd_op == OP_LOAD_WEIGHT && is_weight_sel(cmd_sel)) begin
            weights[cmd_sel] <= cmd_data;
        end
    end

    always_comb begin
        ex_weights = '0;
        for (int i = 0; i < NUM_WEIGHTS; i++) begin
            ex_weights[i*DATA_W +: DATA_W] = weights[i];
        end
    end

endmodule

// File: doc/pedo_issue_ctrl.md
PEDO_ISSUE_CTRL -- requirements
Module: pedo_issue_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- DATA_W, 10, sample/weight/count width
- EX_LATENCY, 1, clk cycles from issue to valid ex_step/ex_updatedSteps (1..4)
- FIFO_DEPTH, 4, sample FIFO entries (power of 2)
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- sample_valid  in  1  accelerometer sample offered
- sample_ready  out  1  FIFO not full
- sample_x  in  DATA_W  X sample
- sample_y  in  DATA_W  Y sample
- cmd_valid  in  1  control command offered
- cmd_ready  out  1  command accepted this cycle
- cmd_op  in  3  0=reset count, 2=load weight; others ignored
- cmd_sel  in  3  weight index 0..5 (theta1_1, theta1_2, theta2_1, theta2_2, alpha1, alpha2)
- cmd_data  in  DATA_W  weight value
- ex_A, ex_B  out  DATA_W  operands to execution unit
- ex_funct  out  3  1=count, 7=NOP
- ex_weights  out  6*DATA_W  six weights, index 0 in LSBs
- ex_totalSteps  out  DATA_W  current count to execution unit
- ex_step  in  1  step decision from execution unit
- ex_updatedSteps  in  DATA_W  new count from execution unit
- step_count  out  DATA_W  committed step count
- step_pulse  out  1  one-cycle pulse per counted step
- busy  out  1  FSM not IDLE or FIFO not empty
- overflow  out  1  sticky, count wrapped

Function
REQ-003 Sample handshake SHALL complete on clk edge with sample_valid && sample_ready; {x,y} pushed into FIFO.
REQ-004 sample_ready SHALL be 0 when FIFO holds FIFO_DEPTH entries; push while full SHALL NOT occur.
REQ-005 Simultaneous push and pop with FIFO full SHALL be legal only if pop frees the slot in the same cycle; sample_ready stays combinationally from registered count (no bypass).
REQ-006 FSM states SHALL be IDLE, ISSUE, WAIT, COMMIT.
REQ-007 IDLE: if cmd_valid, cmd_ready=1 for one cycle and command executes; else if FIFO non-empty, pop head, go ISSUE.
REQ-008 Commands SHALL take priority over samples in IDLE; cmd_ready SHALL be 0 in all other states.
REQ-009 cmd_op=0 SHALL clear step_count and overflow next cycle; cmd_op=2 SHALL write cmd_data to weight cmd_sel; cmd_sel>5 or other op SHALL be accepted and ignored.
REQ-010 ISSUE (1 cycle): ex_A/ex_B = popped sample, ex_funct=1, ex_totalSteps=step_count; go WAIT.
REQ-011 WAIT SHALL hold ex_A/ex_B/ex_funct for EX_LATENCY-1 further cycles via down-counter, then COMMIT.
REQ-012 COMMIT: step_count <= ex_updatedSteps; step_pulse=ex_step; overflow set if ex_step && step_count==all-ones; return IDLE.
REQ-013 Count SHALL wrap all-ones -> 0 (modulo 2^DATA_W); no saturation.
REQ-014 ex_funct SHALL be 7 in IDLE and COMMIT; ex_A/ex_B hold last issued values.
REQ-015 Sample throughput SHALL be one per EX_LATENCY+2 cycles when no commands pending.
REQ-016 ex_weights SHALL be registered and stable except during cmd_op=2 commit.

Reset
REQ-017 rst_n low SHALL asynchronously force: FSM IDLE, FIFO empty, step_count 0, overflow 0, step_pulse 0, weights 0, ex_funct 7, ex_A/ex_B/ex_totalSteps 0, cmd_ready 0.
REQ-018 Reset mid-operation SHALL discard in-flight and queued samples; no COMMIT after release.
REQ-019 sample_ready SHALL be 0 while rst_n low, 1 from first clk after release.

Structure
REQ-020 Shared package SHALL hold funct codes (COUNT=1, NOP=7), cmd_op codes, weight index constants, FSM state enum.
REQ-021 Sample FIFO SHALL be one sub-module, pedo_sample_fifo (parameterised DATA_W, FIFO_DEPTH).

Verification
REQ-022 Load weights 0..5 = 1,2,3,4,5,6 -> ex_weights fields read 1..6, no sample issued.
REQ-023 Push x=100,y=200, model ex_step=1, ex_updatedSteps=count+1 -> ex_funct=1 for EX_LATENCY cycles, step_count 0->1, one step_pulse.
REQ-024 Push 6 samples back-to-back, DEPTH 4 -> sample_ready drops after 4th (+pop), all 6 issued in order, count=6.
REQ-025 step_count=1023, ex_step=1 -> step_count=0, overflow=1 sticky; cmd_op=0 clears both.
REQ-026 cmd_valid and FIFO non-empty together in IDLE -> command accepted first, sample issued next IDLE.
REQ-027 rst_n low during WAIT -> no COMMIT, count 0, FIFO empty, ex_funct=7.
